// File: rtl/mii_mon_pkg.sv
// Shared types and DATA_W-dependent symbol constants for the MII/RMII receive monitor.
// Symbol helpers return 4-bit values; callers truncate to DATA_W.
package mii_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DRAIN    = 2'd3
  } mon_state_e;

  // Low symbol of the 0x55 preamble byte.
  function automatic logic [3:0] pre_sym(input int data_w);
    return (data_w == 4) ? 4'h5 : 4'h1;
  endfunction

  // Last (high) symbol of the 0xD5 start-of-frame delimiter.
  function automatic logic [3:0] sfd_sym(input int data_w);
    return (data_w == 4) ? 4'hD : 4'h3;
  endfunction

  function automatic int sym_per_byte(input int data_w);
    return 8 / data_w;
  endfunction

endpackage

// File: rtl/led_stretch.sv
// Pulse stretcher: each trig reloads an all-ones down-counter; led is high while it is non-zero.
module led_stretch #(
  parameter int STRETCH_W = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic led
);

  logic [STRETCH_W-1:0] cnt_q;
  logic [STRETCH_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trig) begin
      cnt_d = '1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - STRETCH_W'(1);
    end
  end

  // led is registered from the next count so it is high for exactly 2^STRETCH_W-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led   <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/mii_rx_monitor.sv
// MII/RMII receive monitor: preamble/SFD tracking, byte assembly, frame/error counters,
// sticky line-activity bits and stretched activity/error LEDs.
module mii_rx_monitor
  import mii_mon_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int CNT_W     = 16,
  parameter int STRETCH_W = 22
) (
  input  logic              E_RX_CLK,
  input  logic              RST_N,
  input  logic              E_RX_DV,
  input  logic [DATA_W-1:0] E_RXD,
  input  logic              E_RX_ER,
  input  logic              CLR,
  output logic [DATA_W-1:0] sticky,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  output logic              sof,
  output logic              eof,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              LED_ACT,
  output logic              LED_ERR,
  output mon_state_e        state
);

  if (DATA_W != 4 && DATA_W != 2) begin : g_bad_data_w
    $error("mii_rx_monitor: DATA_W must be 4 (MII) or 2 (RMII)");
  end

  localparam logic [DATA_W-1:0] PRE_SYM  = DATA_W'(pre_sym(DATA_W));
  localparam logic [DATA_W-1:0] SFD_SYM  = DATA_W'(sfd_sym(DATA_W));
  localparam logic [1:0]        IDX_LAST = 2'(sym_per_byte(DATA_W) - 1);

  // Stage 0: registered PHY pins.
  logic              dv_q;
  logic [DATA_W-1:0] rxd_q;
  logic              er_q;

  // Stage 1: FSM and internal event strobes.
  mon_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] asm_byte;
  logic       byte_ev, sof_ev, eof_ev, good_ev, err_ev;
  logic       ev_byte_q, ev_sof_q, ev_eof_q, ev_good_q, ev_err_q;
  logic [7:0] ev_data_q;

  assign state = state_q;

  always_ff @(posedge E_RX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      dv_q  <= 1'b0;
      rxd_q <= '0;
      er_q  <= 1'b0;
    end else begin
      dv_q  <= E_RX_DV;
      rxd_q <= E_RXD;
      er_q  <= E_RX_ER;
    end
  end

  // Symbols arrive low-first, so each new one enters at the top and shifts right.
  assign asm_byte = {rxd_q, shreg_q[7:DATA_W]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    byte_ev = 1'b0;
    sof_ev  = 1'b0;
    eof_ev  = 1'b0;
    good_ev = 1'b0;
    err_ev  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dv_q) begin
          if (rxd_q == PRE_SYM) begin
            state_d = ST_PREAMBLE;
          end else begin
            state_d = ST_DRAIN;
            err_ev  = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (er_q) begin
          state_d = ST_DRAIN;
          err_ev  = 1'b1;
        end else if (rxd_q == SFD_SYM) begin
          state_d = ST_DATA;
          sof_ev  = 1'b1;
          idx_d   = 2'd0;
        end else if (rxd_q != PRE_SYM) begin
          state_d = ST_DRAIN;
          err_ev  = 1'b1;
        end
      end
      ST_DATA: begin
        if (!dv_q) begin
          // A frame ending mid-byte (dribble) is counted as an error.
          state_d = ST_IDLE;
          eof_ev  = 1'b1;
          good_ev = (idx_q == 2'd0);
          err_ev  = (idx_q != 2'd0);
        end else if (er_q) begin
          state_d = ST_DRAIN;
          eof_ev  = 1'b1;
          err_ev  = 1'b1;
        end else begin
          shreg_d = asm_byte;
          if (idx_q == IDX_LAST) begin
            byte_ev = 1'b1;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge E_RX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      shreg_q   <= '0;
      ev_byte_q <= 1'b0;
      ev_sof_q  <= 1'b0;
      ev_eof_q  <= 1'b0;
      ev_good_q <= 1'b0;
      ev_err_q  <= 1'b0;
      ev_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      ev_byte_q <= byte_ev;
      ev_sof_q  <= sof_ev;
      ev_eof_q  <= eof_ev;
      ev_good_q <= good_ev;
      ev_err_q  <= err_ev;
      if (byte_ev) begin
        ev_data_q <= asm_byte;
      end
    end
  end

  // Stage 2: outputs. byte_data is meaningful only in the cycle byte_valid is high;
  // there is no back-pressure, so a consumer must take each byte on its strobe.
  always_ff @(posedge E_RX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_valid <= 1'b0;
      byte_data  <= '0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      sticky     <= '0;
    end else begin
      byte_valid <= ev_byte_q;
      sof        <= ev_sof_q;
      eof        <= ev_eof_q;
      if (ev_byte_q) begin
        byte_data <= ev_data_q;
      end
      if (CLR) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
        sticky    <= '0;
      end else begin
        if (ev_good_q && frame_cnt != '1) begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
        if (ev_err_q && err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        sticky <= sticky | rxd_q;
      end
    end
  end

  led_stretch #(.STRETCH_W(STRETCH_W)) u_led_act (
    .clk   (E_RX_CLK),
    .rst_n (RST_N),
    .trig  (ev_sof_q),
    .led   (LED_ACT)
  );

  led_stretch #(.STRETCH_W(STRETCH_W)) u_led_err (
    .clk   (E_RX_CLK),
    .rst_n (RST_N),
    .trig  (ev_err_q),
    .led   (LED_ERR)
  );

endmodule

// File: tb/tb_mii_rx_monitor.sv
// Bench for mii_rx_monitor: MII instance (CNT_W=2, STRETCH_W=4) driven by a frame table
// plus hand sequences, and an RMII instance for dibit assembly.
module tb_mii_rx_monitor;
  import mii_mon_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MII instance
  logic       dv, er, clr;
  logic [3:0] rxd;
  logic [3:0] sticky;
  logic [7:0] byte_data;
  logic       byte_valid, sof, eof, led_act, led_err;
  logic [1:0] frame_cnt, err_cnt;
  mon_state_e state;

  // RMII instance
  logic        dv2, er2, clr2;
  logic [1:0]  rxd2;
  logic [1:0]  sticky2;
  logic [7:0]  byte_data2;
  logic        byte_valid2, sof2, eof2, led_act2, led_err2;
  logic [15:0] frame_cnt2, err_cnt2;
  mon_state_e  state2;

  mii_rx_monitor #(.DATA_W(4), .CNT_W(2), .STRETCH_W(4)) u_dut (
    .E_RX_CLK(clk), .RST_N(rst_n), .E_RX_DV(dv), .E_RXD(rxd), .E_RX_ER(er), .CLR(clr),
    .sticky(sticky), .byte_data(byte_data), .byte_valid(byte_valid), .sof(sof), .eof(eof),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .LED_ACT(led_act), .LED_ERR(led_err),
    .state(state)
  );

  mii_rx_monitor #(.DATA_W(2), .CNT_W(16), .STRETCH_W(4)) u_dut2 (
    .E_RX_CLK(clk), .RST_N(rst_n), .E_RX_DV(dv2), .E_RXD(rxd2), .E_RX_ER(er2), .CLR(clr2),
    .sticky(sticky2), .byte_data(byte_data2), .byte_valid(byte_valid2), .sof(sof2), .eof(eof2),
    .frame_cnt(frame_cnt2), .err_cnt(err_cnt2), .LED_ACT(led_act2), .LED_ERR(led_err2),
    .state(state2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_bv, n_sof, n_eof, n_act, n_eled;
  int n_bv2, n_sof2;
  logic [7:0] last2;
  logic [7:0] exp_q[$];
  logic [7:0] e_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_counts();
    n_bv = 0; n_sof = 0; n_eof = 0; n_act = 0; n_eled = 0;
  endtask

  always @(negedge clk) begin
    if (byte_valid) begin
      n_bv++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL byte_unexpected: got 0x%0h expected none", byte_data);
      end else begin
        e_byte = exp_q.pop_front();
        check("byte_data", {24'd0, byte_data}, {24'd0, e_byte});
      end
    end
    if (eof) begin
      n_eof++;
      check("eof_byte_overlap", {31'd0, byte_valid}, 32'd0);
    end
    if (sof) n_sof++;
    if (led_act) n_act++;
    if (led_err) n_eled++;
    if (byte_valid2) begin
      n_bv2++;
      last2 = byte_data2;
    end
    if (sof2) n_sof2++;
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [3:0] d, input logic e);
    dv = v; rxd = d; er = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    clr = 1'b0;
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 8'(k));
  endtask

  // pre preamble nibbles, one delimiter nibble, then nibs data nibbles (low first).
  // Leaves DV high on the last symbol.
  task automatic send_frame(input int pre, input logic [3:0] sfd, input int nibs,
                            input int er_at, input logic [7:0] base);
    logic [7:0] b;
    logic [3:0] nib;
    for (int i = 0; i < pre; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, sfd, 1'b0);
    for (int j = 0; j < nibs; j++) begin
      b   = base + 8'(j / 2);
      nib = (j % 2 == 0) ? b[3:0] : b[7:4];
      drive(1'b1, nib, (j == er_at));
    end
  endtask

  task automatic drive2(input logic v, input logic [1:0] d);
    dv2 = v; rxd2 = d; er2 = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         pre;
    logic [3:0] sfd;
    int         nibs;
    int         er_at;
    logic [7:0] base;
    int         e_bv, e_sof, e_eof, e_frm, e_err, e_act, e_eled;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{15, 4'hD, 128, -1, 8'h00, 64, 1, 1, 1, 0, 15, 0};  // 64-byte good frame
    tbl[1] = '{2,  4'h7, 10,  -1, 8'h00, 0,  0, 0, 0, 1, 0, 15};  // 5,5,7 bad preamble, DV held
    tbl[2] = '{15, 4'hD, 20,  10, 8'h40, 5,  1, 1, 0, 1, 15, 15}; // ER after 5 bytes
    tbl[3] = '{15, 4'hD, 3,   -1, 8'h12, 1,  1, 1, 0, 1, 15, 15}; // odd-nibble dribble
    tbl[4] = '{1,  4'hD, 4,   -1, 8'hA5, 2,  1, 1, 1, 0, 15, 0};  // minimal preamble
    tbl[5] = '{0,  4'hD, 4,   -1, 8'h00, 0,  0, 0, 0, 1, 0, 15};  // DV starts on non-preamble
    tbl[6] = '{6,  4'h5, 0,   -1, 8'h00, 0,  0, 0, 0, 0, 0, 0};   // DV drops in preamble

    rst_n = 1'b0; dv = 0; rxd = 0; er = 0; clr = 0;
    dv2 = 0; rxd2 = 0; er2 = 0; clr2 = 0;
    n_bv2 = 0; n_sof2 = 0; last2 = 0;
    clear_counts();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {9'd0, sticky, byte_data, byte_valid, sof, eof, frame_cnt, err_cnt,
                          led_act, led_err, state}, 32'd0);

    // ---- table ----
    for (int r = 0; r < 7; r++) begin
      pulse_clr();
      clear_counts();
      push_bytes(tbl[r].base, tbl[r].e_bv);
      send_frame(tbl[r].pre, tbl[r].sfd, tbl[r].nibs, tbl[r].er_at, tbl[r].base);
      idle(24);
      check($sformatf("r%0d_byte_valid", r), n_bv, tbl[r].e_bv);
      check($sformatf("r%0d_sof", r), n_sof, tbl[r].e_sof);
      check($sformatf("r%0d_eof", r), n_eof, tbl[r].e_eof);
      check($sformatf("r%0d_frame_cnt", r), {30'd0, frame_cnt}, tbl[r].e_frm);
      check($sformatf("r%0d_err_cnt", r), {30'd0, err_cnt}, tbl[r].e_err);
      check($sformatf("r%0d_led_act", r), n_act, tbl[r].e_act);
      check($sformatf("r%0d_led_err", r), n_eled, tbl[r].e_eled);
      check($sformatf("r%0d_exp_q_left", r), exp_q.size(), 0);
    end

    // ---- sticky bits ----
    pulse_clr();
    check("sticky_after_clr", {28'd0, sticky}, 32'h0);
    send_frame(6, 4'h5, 0, -1, 8'h00);
    idle(4);
    check("sticky_preamble_only", {28'd0, sticky}, 32'h5);
    push_bytes(8'h00, 64);
    send_frame(15, 4'hD, 128, -1, 8'h00);
    idle(24);
    check("sticky_full_frame", {28'd0, sticky}, 32'hF);
    check("frame_cnt_sticky_run", {30'd0, frame_cnt}, 32'd1);
    pulse_clr();
    check("sticky_cleared", {28'd0, sticky}, 32'h0);
    check("frame_cnt_cleared", {30'd0, frame_cnt}, 32'd0);

    // ---- SFD-to-sof latency ----
    clear_counts();
    push_bytes(8'h00, 1);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    check("sof_lat_edge1", {31'd0, sof}, 32'd0);
    drive(1'b1, 4'h0, 1'b0);
    check("sof_lat_edge2", {31'd0, sof}, 32'd0);
    drive(1'b1, 4'h0, 1'b0);
    check("sof_lat_edge3", {31'd0, sof}, 32'd1);
    idle(24);
    check("lat_frame_cnt", {30'd0, frame_cnt}, 32'd1);
    check("lat_bytes", n_bv, 1);

    // ---- saturation and CLR/increment collision ----
    pulse_clr();
    for (int f = 0; f < 5; f++) begin
      push_bytes(8'h10 * 8'(f), 2);
      send_frame(15, 4'hD, 4, -1, 8'h10 * 8'(f));
      idle(4);
    end
    check("frame_cnt_saturated", {30'd0, frame_cnt}, 32'd3);
    check("err_cnt_sat_run", {30'd0, err_cnt}, 32'd0);
    push_bytes(8'h60, 2);
    send_frame(15, 4'hD, 4, -1, 8'h60);
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    clr = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    clr = 1'b0;
    check("clr_eof_edge", {31'd0, eof}, 32'd1);
    check("clr_beats_increment", {30'd0, frame_cnt}, 32'd0);
    idle(20);
    check("frame_cnt_after_clr", {30'd0, frame_cnt}, 32'd0);
    check("sat_exp_q_left", exp_q.size(), 0);

    // ---- reset in the middle of DATA ----
    pulse_clr();
    push_bytes(8'h00, 3);
    send_frame(15, 4'hD, 6, -1, 8'h00);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {9'd0, sticky, byte_data, byte_valid, sof, eof, frame_cnt,
                                     err_cnt, led_act, led_err, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    clear_counts();
    send_frame(0, 4'h3, 7, -1, 8'h04);
    idle(24);
    check("rst_tail_err_cnt", {30'd0, err_cnt}, 32'd1);
    check("rst_tail_frame_cnt", {30'd0, frame_cnt}, 32'd0);
    check("rst_tail_bytes", n_bv, 0);
    check("rst_tail_eof", n_eof, 0);
    check("rst_tail_led_err", n_eled, 15);

    // ---- RMII dibits ----
    n_bv2 = 0; n_sof2 = 0;
    for (int i = 0; i < 31; i++) drive2(1'b1, 2'b01);
    drive2(1'b1, 2'b11);
    drive2(1'b1, 2'b01);
    drive2(1'b1, 2'b01);
    drive2(1'b1, 2'b10);
    drive2(1'b1, 2'b10);
    repeat (24) drive2(1'b0, 2'b00);
    check("rmii_byte", {24'd0, last2}, 32'hA5);
    check("rmii_byte_count", n_bv2, 1);
    check("rmii_sof", n_sof2, 1);
    check("rmii_frame_cnt", {16'd0, frame_cnt2}, 32'd1);
    check("rmii_err_cnt", {16'd0, err_cnt2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mii_rx_monitor.md
# mii_rx_monitor

Parametrised receive-side monitor for the MII/RMII PHY interface. It samples the PHY receive bus and tracks preamble/SFD, assembles data symbols into bytes, and counts good and errored frames. It keeps sticky per-line activity bits and drives pulse-stretched activity and error LEDs. The block sits directly behind the PHY receive pins and is the bring-up and diagnostic front end for the later DNS packet path.

## Interface
Parameters:
- DATA_W, 4: PHY symbol width; 4 = MII nibble, 2 = RMII dibit; other values illegal (elaboration error).
- CNT_W, 16: width of frame and error counters.
- STRETCH_W, 22: LED stretch counter width; LED stays on for 2^STRETCH_W − 1 cycles after the last event.

Ports:
- E_RX_CLK  in  1  PHY receive clock; the block's only clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- E_RX_DV  in  1  receive data valid.
- E_RXD  in  DATA_W  receive symbol, least-significant symbol of each byte first.
- E_RX_ER  in  1  receive error.
- CLR  in  1  synchronous clear of sticky bits and counters.
- sticky  out  DATA_W  bit i set once E_RXD[i] is sampled high; held until CLR or reset.
- byte_data  out  8  assembled byte, valid when byte_valid is high.
- byte_valid  out  1  one-cycle strobe per assembled byte.
- sof  out  1  one-cycle strobe on SFD accept.
- eof  out  1  one-cycle strobe on end of a DATA-state frame (good or bad).
- frame_cnt  out  CNT_W  good frames, saturating.
- err_cnt  out  CNT_W  errored frames, saturating.
- LED_ACT  out  1  stretched pulse on each sof.
- LED_ERR  out  1  stretched pulse on each err_cnt event.

## Operation
- Input stage: E_RX_DV, E_RXD and E_RX_ER are registered once; all logic runs on the registered copies.
- PRE_SYM = DATA_W-wide low slice of 0x55 (4'h5 / 2'b01). SFD_SYM = last symbol of 0xD5 (4'hD / 2'b11). SYM_PER_BYTE = 8/DATA_W.
- FSM states: IDLE, PREAMBLE, DATA, DRAIN.
- IDLE: DV=1 and symbol == PRE_SYM → PREAMBLE. DV=1 with any other symbol → DRAIN, error event.
- PREAMBLE: PRE_SYM stays. SFD_SYM → DATA, sof, symbol index cleared. Other symbol or ER → DRAIN, error event. DV=0 → IDLE, no count.
- DATA: symbols shift into byte_data, low symbol first. At index SYM_PER_BYTE−1, byte_valid pulses and the index wraps to 0. ER=1 → DRAIN, error event, eof.
- DATA with DV=0: eof fires. If index == 0, frame_cnt increments. If index != 0 (dribble), err_cnt increments instead. Either way → IDLE.
- DRAIN: wait for DV=0 → IDLE. No bytes are emitted.
- Counters saturate at all-ones. A CLR in the same cycle as an increment wins; result is 0.
- A sticky bit sets on any sampled high, regardless of DV. Same-cycle CLR wins.
- The LED stretcher reloads to all-ones on each event and counts down to 0. The LED is high while the count is non-zero. A retrigger reloads.

## Timing
- Latency 2 cycles: a symbol sampled at edge N produces its effect (byte_valid/sof/eof/counter update) visible after edge N+2.
- All outputs are registered.
- Reset values: all outputs 0, FSM = IDLE, stretchers 0.
- Reset mid-frame drops the partial frame and counts nothing. After release, a frame already in progress is seen as DV=1 with a non-preamble symbol → DRAIN plus one error, or it is ignored if it is still in preamble.
- byte_valid, sof and eof are never high for more than one consecutive cycle each. eof and the final byte_valid never coincide: the final byte strobes at least one cycle before eof.

## Structure
- Package mii_mon_pkg holds the state enum, the PRE_SYM/SFD_SYM functions of DATA_W, and SYM_PER_BYTE.
- Sub-module led_stretch (parameter STRETCH_W; ports clk, rst_n, trig, led) is instantiated twice.

## Test plan
- Good frame, DATA_W=4, STRETCH_W=4: 15×4'h5, 4'hD, bytes 0x00..0x3F → 64 byte_valid with matching byte_data, 1 sof, 1 eof, frame_cnt=1, err_cnt=0, LED_ACT high for 15 cycles.
- DATA_W=2: 31×2'b01, 2'b11, byte 0xA5 (dibits 01,01,10,10) → byte_data=0xA5, frame_cnt=1.
- Preamble 4'h5,4'h5,4'h7 → no sof, err_cnt=1, LED_ERR high. DV held 10 more cycles → still err_cnt=1.
- E_RX_ER pulsed after 5 bytes → eof, err_cnt=1, frame_cnt unchanged, no further byte_valid. Odd-nibble frame (3 nibbles of data) → 1 byte_valid, err_cnt+1.
- CNT_W=2: 5 good frames → frame_cnt=3 (saturated). CLR on the same cycle as the 6th frame's eof → frame_cnt=0. sticky=4'hF after the frame; CLR → 0.
- RST_N low mid-DATA for 1 cycle → all outputs 0. The remainder of the frame → err_cnt=1, no byte_valid.
